irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- small external-interrupt controller.
//
// Synchronises NUM_SRC raw request lines and tracks a pending bit per source.
// Edge sources latch on a synchronised rising edge. Level sources follow the
// synchronised level. The lowest-index source that is pending, enabled and
// not gated is presented to the CPU as one request with a 4-bit cause
// (index + 1). The CPU runs a claim/complete handshake through the CLAIM
// register.
//
// Ports
//   g_clk              in   clock, all state on rising edge
//   g_reset            in   asynchronous active-high reset
//   irq_src[N-1:0]     in   raw asynchronous request lines
//   cfg_valid          in   register access strobe (one per cycle)
//   cfg_we             in   1 = write, 0 = read
//   cfg_addr[1:0]      in   0 ENABLE, 1 EDGE, 2 PENDING (W1C), 3 CLAIM
//   cfg_wdata[31:0]    in   write data
//   cfg_rdata[31:0]    out  read data, registered, held until next read
//   cpu_int_external   out  interrupt request to the CPU
//   cpu_int_ext_cause  out  source index + 1 of the request, 0 when idle
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_valid,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               cpu_int_external,
  output logic [3:0]         cpu_int_ext_cause
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_CLAIMED = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] gated_q;
  state_t             state_q;
  logic [3:0]         cur_q;
  logic               int_q;
  logic [3:0]         cause_q;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_en, rd_en;
  logic               claim_rd, claim_wr_ok, disable_cur;
  logic [NUM_SRC-1:0] wdata_src;
  logic [NUM_SRC-1:0] cur_oh, rise, clr, cand;
  logic [3:0]         cur_id;
  logic [3:0]         sel_idx;
  logic               sel_any;

  // Upper write-data bits are architecturally ignored.
  logic               unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  assign wr_en     = cfg_valid & cfg_we;
  assign rd_en     = cfg_valid & ~cfg_we;
  assign wdata_src = cfg_wdata[NUM_SRC-1:0];
  assign cur_id    = cur_q + 4'd1;

  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cur_oh[i] = (cur_q == 4'(i));
    end
  end

  // A CLAIM read only claims while a request is being presented.
  assign claim_rd    = rd_en && (cfg_addr == ADDR_CLAIM) && (state_q == ST_ASSERT);
  assign claim_wr_ok = wr_en && (cfg_addr == ADDR_CLAIM) && (cfg_wdata[3:0] == cur_id);
  assign disable_cur = wr_en && (cfg_addr == ADDR_ENABLE) && ((wdata_src & cur_oh) == '0);

  // ---- stage: input synchroniser + edge-detect flop ----
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // ---- stage: configuration and pending registers ----
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_en && (cfg_addr == ADDR_ENABLE)) enable_d = wdata_src;
    if (wr_en && (cfg_addr == ADDR_EDGE))   edge_d   = wdata_src;
  end

  // Edge bits: a new rising edge overrides a same-cycle clear (W1C or claim).
  // Level bits simply track the synchronised line.
  always_comb begin
    clr = '0;
    if (wr_en && (cfg_addr == ADDR_PENDING)) clr = wdata_src;
    if (claim_rd)                            clr = clr | cur_oh;
    pending_d = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & sync2_q);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
    end else begin
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
    end
  end

  // ---- stage: fixed-priority selection (lowest index wins) ----
  assign cand    = pending_q & enable_q & ~gated_q;
  assign sel_any = |cand;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = 4'(i);
    end
  end

  // ---- stage: claim/complete FSM with registered outputs ----
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      gated_q <= '0;
      int_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_any) begin
            cur_q   <= sel_idx;
            state_q <= ST_ASSERT;
            int_q   <= 1'b1;
            cause_q <= sel_idx + 4'd1;
          end
        end
        ST_ASSERT: begin
          // cur is held here; a newly pending higher-priority source waits.
          if (claim_rd) begin
            gated_q <= cur_oh;
            state_q <= ST_CLAIMED;
            int_q   <= 1'b0;
            cause_q <= '0;
          end else if (disable_cur) begin
            state_q <= ST_IDLE;
            int_q   <= 1'b0;
            cause_q <= '0;
          end
        end
        ST_CLAIMED: begin
          if (claim_wr_ok) begin
            gated_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          int_q   <= 1'b0;
          cause_q <= '0;
        end
      endcase
    end
  end

  // ---- stage: register read port ----
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (cfg_addr)
        ADDR_ENABLE:  rdata_d = 32'(enable_q);
        ADDR_EDGE:    rdata_d = 32'(edge_q);
        ADDR_PENDING: rdata_d = 32'(pending_q);
        ADDR_CLAIM:   rdata_d = (state_q == ST_ASSERT) ? {1'b1, 27'b0, cur_id} : 32'd0;
        default:      rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign cfg_rdata         = rdata_q;
  assign cpu_int_external  = int_q;
  assign cpu_int_ext_cause = cause_q;

endmodule
